// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem and feeds decode through
// a valid/ready IF/ID register with redirect, stall and halt handling.
module fetch_stage #(
    parameter int            n          = 16,
    parameter int            r          = 5,
    parameter logic [r-1:0]  RESET_PC   = '0,
    parameter logic [n-1:0]  HALT_INSTR = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [r-1:0] imem_pc,
    input  logic [n-1:0] imem_instr,
    input  logic         redirect,
    input  logic [r-1:0] redirect_pc,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [n-1:0] id_instr,
    output logic [r-1:0] id_pc,
    output logic         halted
);

    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [r-1:0] PC_ONE = r'(1);

    state_t       state;
    logic [r-1:0] pc;
    logic         xfer;
    logic         space;

    assign imem_pc = pc;
    assign xfer    = id_valid & id_ready;
    assign space   = ~id_valid | id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
            state    <= RUN;
            halted   <= 1'b0;
        end else if (redirect) begin
            // The held word is discarded; its pc/instr fields simply go stale.
            pc       <= redirect_pc;
            id_valid <= 1'b0;
            state    <= RUN;
            halted   <= 1'b0;
        end else if (state == HALTED) begin
            if (xfer)
                id_valid <= 1'b0;
        end else if (en && space) begin
            id_instr <= imem_instr;
            id_pc    <= pc;
            id_valid <= 1'b1;
            if (imem_instr == HALT_INSTR) begin
                state  <= HALTED;
                halted <= 1'b1;
            end else begin
                pc <= pc + PC_ONE;
            end
        end else if (xfer) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized traffic
// checked against a fetch-pointer / consume-order reference model.
module tb_fetch_stage;

    localparam int N = 16;
    localparam int R = 5;
    localparam logic [N-1:0] HALT = 16'hFFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [R-1:0] imem_pc;
    logic [N-1:0] imem_instr;
    logic         redirect;
    logic [R-1:0] redirect_pc;
    logic         id_valid;
    logic         id_ready;
    logic [N-1:0] id_instr;
    logic [R-1:0] id_pc;
    logic         halted;

    logic [N-1:0] mem [32];

    int checks = 0;
    int errors = 0;

    // model: next fetch address, halt flag, next expected consumed address
    logic [R-1:0] f;
    logic [R-1:0] c;
    bit           m_halt;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .imem_pc    (imem_pc),
        .imem_instr (imem_instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .halted     (halted)
    );

    assign imem_instr = mem[imem_pc];

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        f      = '0;
        c      = '0;
        m_halt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        en          = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", imem_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cycle(bit e, bit rd, bit redir, logic [R-1:0] rpc);
        bit           v0;
        bit           load;
        logic [R-1:0] p0;
        logic [N-1:0] i0;
        en          = e;
        id_ready    = rd;
        redirect    = redir;
        redirect_pc = rpc;
        v0   = id_valid;
        p0   = id_pc;
        i0   = id_instr;
        load = !redir && !m_halt && e && (!v0 || rd);
        if (v0 && rd) begin
            chk("cons_pc", p0, c);
            chk("cons_instr", i0, mem[p0]);
            c = p0 + 1'b1;
        end
        if (redir)
            c = rpc;
        @(posedge clk);
        #1;
        if (redir) begin
            f      = rpc;
            m_halt = 1'b0;
            chk("flush_valid", id_valid, 0);
        end else if (load) begin
            chk("load_valid", id_valid, 1);
            chk("load_pc", id_pc, f);
            chk("load_instr", id_instr, mem[f]);
            if (mem[f] == HALT)
                m_halt = 1'b1;
            else
                f = f + 1'b1;
        end else if (v0 && !rd) begin
            chk("hold_valid", id_valid, 1);
            chk("hold_pc", id_pc, p0);
            chk("hold_instr", id_instr, i0);
        end else begin
            chk("idle_valid", id_valid, 0);
        end
        chk("imem_pc", imem_pc, f);
        chk("halted", halted, m_halt);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = 16'(i * 16'h0101 + 16'h0005);
        mem[0]  = 16'h1111;
        mem[1]  = 16'h2222;
        mem[2]  = 16'h3333;
        mem[3]  = 16'h4444;
        mem[4]  = HALT;
        mem[31] = 16'h0ABC;
        do_reset();

        // stream
        cycle(1, 1, 0, 0);
        chk("t1_w0", {id_pc, id_instr}, {5'd0, 16'h1111});
        cycle(1, 1, 0, 0);
        chk("t1_w1", {id_pc, id_instr}, {5'd1, 16'h2222});

        // backpressure
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0);
            chk("t2_frozen", {id_valid, id_pc, id_instr}, {1'b1, 5'd1, 16'h2222});
            chk("t2_imem_pc", imem_pc, 2);
        end
        cycle(1, 1, 0, 0);
        chk("t2_resume", {id_pc, id_instr}, {5'd2, 16'h3333});
        cycle(1, 1, 0, 0);
        chk("t1_w3", {id_pc, id_instr}, {5'd3, 16'h4444});

        // redirect with bubble
        cycle(1, 1, 1, 5'd20);
        chk("t3_bubble", id_valid, 0);
        chk("t3_imem_pc", imem_pc, 20);
        cycle(1, 1, 0, 0);
        chk("t3_target", {id_valid, id_pc}, {1'b1, 5'd20});

        // halt
        cycle(1, 1, 1, 5'd4);
        cycle(1, 1, 0, 0);
        chk("t4_halt", {halted, id_pc, id_instr}, {1'b1, 5'd4, HALT});
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0);
            chk("t4_idle", {id_valid, imem_pc}, {1'b0, 5'd4});
        end
        cycle(1, 1, 1, 5'd0);
        chk("t4_unhalt", halted, 0);
        cycle(1, 1, 0, 0);
        chk("t4_restart", {id_pc, id_instr}, {5'd0, 16'h1111});

        // wrap
        cycle(1, 1, 1, 5'd31);
        chk("t5_pc31", imem_pc, 31);
        cycle(1, 1, 0, 0);
        chk("t5_w31", {id_pc, id_instr, imem_pc}, {5'd31, 16'h0ABC, 5'd0});
        cycle(1, 1, 0, 0);
        chk("t5_w0", {id_pc, id_instr, imem_pc}, {5'd0, 16'h1111, 5'd1});

        // async reset mid-stall
        cycle(1, 0, 0, 0);
        chk("t6_stalled", id_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", id_valid, 0);
        chk("t6_async_pc", imem_pc, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(1, 1, 0, 0);
        chk("t6_after", {id_pc, id_instr}, {5'd0, 16'h1111});

        // randomized traffic
        for (int i = 0; i < 32; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? HALT : 16'($urandom);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit redir;
            redir = ($urandom_range(0, 15) == 0) ||
                    (m_halt && $urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  redir, R'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
